// File: rtl/keypad_scan_fifo.sv
// Keypad front end: synchronizes and debounces the 16-button pad, then queues one
// 4-bit key code per accepted press in a first-word-fall-through FIFO.
module keypad_scan_fifo #(
   parameter int DB_TICKS = 3,
   parameter int DEPTH    = 8,
   parameter int PTR_W    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_tick,
   input  logic [15:0]      pb,
   input  logic             rd_en,
   output logic [3:0]       key_code,
   output logic             key_valid,
   output logic [PTR_W:0]   key_count,
   output logic             overflow,
   input  logic             clr_overflow
);

   localparam logic [3:0]     DB_LAST    = 4'(DB_TICKS);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

   state_t           state, state_next;
   logic [15:0]      sync_a, sync_b;
   logic [4:0]       ones;
   logic [3:0]       idx;
   logic             one_hot;
   logic             released;
   logic             same_key;
   logic [3:0]       cand, cand_next;
   logic [3:0]       cnt, cnt_next;
   logic [3:0]       cnt_inc;
   logic             push;
   logic [3:0]       push_code;
   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             full;
   logic             pop;
   logic             write;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= pb;
         sync_b <= sync_a;
      end
   end

   // Population count doubles as the one-hot test; idx is only meaningful when one_hot.
   always_comb begin
      ones = '0;
      idx  = '0;
      for (int i = 0; i < 16; i++) begin
         if (sync_b[i]) begin
            ones = ones + 5'd1;
            idx  = 4'(i);
         end
      end
      one_hot = (ones == 5'd1);
   end

   assign released = (sync_b == 16'd0);
   assign same_key = one_hot && (idx == cand);
   assign cnt_inc  = cnt + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cand  <= cand_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cand_next  = cand;
      cnt_next   = cnt;
      if (sample_tick) begin
         case (state)
            IDLE: begin
               if (one_hot) begin
                  cand_next = idx;
                  cnt_next  = 4'd1;
                  if (DB_TICKS == 1) state_next = HELD;
                  else               state_next = PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (same_key) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == DB_LAST) state_next = HELD;
               end else begin
                  state_next = IDLE;
               end
            end
            HELD: begin
               if (released) begin
                  cnt_next = 4'd1;
                  if (DB_TICKS == 1) state_next = IDLE;
                  else               state_next = REL_DB;
               end
            end
            REL_DB: begin
               if (released) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == DB_LAST) state_next = IDLE;
               end else begin
                  state_next = HELD;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // A single-tick debounce pushes straight out of IDLE using the live index.
   always_comb begin
      push      = 1'b0;
      push_code = cand;
      if (sample_tick) begin
         case (state)
            IDLE: begin
               if (one_hot && (DB_TICKS == 1)) begin
                  push      = 1'b1;
                  push_code = idx;
               end
            end
            PRESS_DB: begin
               if (same_key && (cnt_inc == DB_LAST)) push = 1'b1;
            end
            default: push = 1'b0;
         endcase
      end
   end

   assign key_valid = (key_count != '0);
   assign full      = (key_count == FULL_COUNT);
   assign pop       = rd_en && key_valid;
   assign write     = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (write) mem[wr_ptr] <= push_code;
   end

   // When full, a simultaneous pop frees the slot the push lands in, so count holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         key_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (write) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (write && !pop)      key_count <= key_count + 1'b1;
         else if (!write && pop) key_count <= key_count - 1'b1;
         if (push && full && !pop) overflow <= 1'b1;
         else if (clr_overflow)    overflow <= 1'b0;
      end
   end

   assign key_code = key_valid ? mem[rd_ptr] : 4'd0;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Self-checking bench for keypad_scan_fifo: directed scenarios plus randomized
// key patterns checked against a press-acceptance and queue model.
module tb_keypad_scan_fifo;

   localparam int DB    = 3;
   localparam int DEPTH = 8;
   localparam int PTR_W = 3;

   logic             clk;
   logic             rst;
   logic             sample_tick;
   logic [15:0]      pb;
   logic             rd_en;
   logic [3:0]       key_code;
   logic             key_valid;
   logic [PTR_W:0]   key_count;
   logic             overflow;
   logic             clr_overflow;

   int tests;
   int fails;

   keypad_scan_fifo #(.DB_TICKS(DB), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk),
      .rst(rst),
      .sample_tick(sample_tick),
      .pb(pb),
      .rd_en(rd_en),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_count(key_count),
      .overflow(overflow),
      .clr_overflow(clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a pad pattern, let it cross the synchronizer, then issue one sample tick.
   task automatic do_tick(input logic [15:0] pat, input logic with_pop);
      @(negedge clk);
      pb = pat;
      repeat (2) @(negedge clk);
      sample_tick = 1'b1;
      rd_en       = with_pop;
      @(negedge clk);
      sample_tick = 1'b0;
      rd_en       = 1'b0;
   endtask

   task automatic do_pop();
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic press(input int k);
      repeat (DB) do_tick(16'h1 << k, 1'b0);
      repeat (DB) do_tick(16'h0, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      pb  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", key_valid); end
      tests++; if (key_count !== 4'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", key_count); end
      tests++; if (key_code !== 4'd0) begin fails++; $display("[TB] FAIL reset_code: got %0d expected 0", key_code); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_valid: got %0b expected 0", key_valid); end
   endtask

   task automatic test_single_press();
      for (int t = 1; t <= 5; t++) begin
         do_tick(16'h1 << 7, 1'b0);
         if (t == 2) begin
            tests++; if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_early: got valid %0b expected 0", key_valid); end
         end
         if (t == 3) begin
            tests++; if (key_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid: got %0b expected 1", key_valid); end
            tests++; if (key_code !== 4'd7) begin fails++; $display("[TB] FAIL single_code: got %0d expected 7", key_code); end
         end
      end
      repeat (5) do_tick(16'h0, 1'b0);
      tests++; if (key_count !== 4'd1) begin fails++; $display("[TB] FAIL single_count: got %0d expected 1", key_count); end
      do_pop();
      tests++; if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_pop_empty: got valid %0b expected 0", key_valid); end
      do_pop();
      tests++; if (key_count !== 4'd0) begin fails++; $display("[TB] FAIL empty_pop_ignored: got count %0d expected 0", key_count); end
   endtask

   task automatic test_bounce();
      logic [15:0] seq [5];
      seq = '{16'h0008, 16'h0000, 16'h0008, 16'h0008, 16'h0008};
      for (int t = 0; t < 5; t++) begin
         do_tick(seq[t], 1'b0);
         if (t == 3) begin
            tests++; if (key_count !== 4'd0) begin fails++; $display("[TB] FAIL bounce_early: got count %0d expected 0", key_count); end
         end
      end
      tests++; if (key_count !== 4'd1) begin fails++; $display("[TB] FAIL bounce_push: got count %0d expected 1", key_count); end
      tests++; if (key_code !== 4'd3) begin fails++; $display("[TB] FAIL bounce_code: got %0d expected 3", key_code); end
      repeat (DB) do_tick(16'h0, 1'b0);
      repeat (2) do_tick(16'h1 << 5, 1'b0);
      repeat (DB) do_tick(16'h0, 1'b0);
      tests++; if (key_count !== 4'd1) begin fails++; $display("[TB] FAIL glitch_count: got %0d expected 1", key_count); end
      do_pop();
   endtask

   task automatic test_chord();
      repeat (DB) do_tick(16'h1 << 2, 1'b0);
      repeat (2) do_tick((16'h1 << 2) | (16'h1 << 9), 1'b0);
      repeat (DB) do_tick(16'h0, 1'b0);
      tests++; if (key_count !== 4'd1) begin fails++; $display("[TB] FAIL chord_hold_count: got %0d expected 1", key_count); end
      tests++; if (key_code !== 4'd2) begin fails++; $display("[TB] FAIL chord_hold_code: got %0d expected 2", key_code); end
      do_pop();
      repeat (4) do_tick((16'h1 << 1) | (16'h1 << 4), 1'b0);
      repeat (DB) do_tick(16'h0, 1'b0);
      tests++; if (key_count !== 4'd0) begin fails++; $display("[TB] FAIL chord_idle_count: got %0d expected 0", key_count); end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 9; k++) press(k);
      tests++; if (key_count !== 4'd8) begin fails++; $display("[TB] FAIL ovf_count: got %0d expected 8", key_count); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
      for (int k = 0; k < 8; k++) begin
         tests++; if (key_code !== 4'(k)) begin fails++; $display("[TB] FAIL ovf_order: got %0d expected %0d", key_code, k); end
         do_pop();
      end
      tests++; if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL ovf_drained: got valid %0b expected 0", key_valid); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", overflow); end
      @(negedge clk);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clear: got %0b expected 0", overflow); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp [8];
      exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
      for (int k = 0; k < 8; k++) press(k);
      repeat (DB - 1) do_tick(16'h1 << 10, 1'b0);
      do_tick(16'h1 << 10, 1'b1);
      tests++; if (key_count !== 4'd8) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 8", key_count); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL b2b_overflow: got %0b expected 0", overflow); end
      repeat (DB) do_tick(16'h0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tests++; if (key_code !== exp[k]) begin fails++; $display("[TB] FAIL b2b_order: got %0d expected %0d", key_code, exp[k]); end
         do_pop();
      end
   endtask

   task automatic test_reset_mid();
      press(4);
      press(5);
      press(6);
      do_tick(16'h1 << 11, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      tests++; if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_valid: got %0b expected 0", key_valid); end
      tests++; if (key_count !== 4'd0) begin fails++; $display("[TB] FAIL midrst_count: got %0d expected 0", key_count); end
      tests++; if (key_code !== 4'd0) begin fails++; $display("[TB] FAIL midrst_code: got %0d expected 0", key_code); end
      @(negedge clk);
      pb = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      press(12);
      tests++; if (key_count !== 4'd1) begin fails++; $display("[TB] FAIL midrst_after_count: got %0d expected 1", key_count); end
      tests++; if (key_code !== 4'd12) begin fails++; $display("[TB] FAIL midrst_after_code: got %0d expected 12", key_code); end
      do_pop();
   endtask

   // Model: a press is accepted after DB identical single-key samples taken while
   // the pad is armed; it re-arms only after DB consecutive all-released samples.
   task automatic test_random();
      logic [3:0]  q [$];
      logic        model_ovf;
      bit          armed;
      int          run_len, zero_len;
      int          run_key, k;
      logic [15:0] pat;
      bit          with_pop, popped, accepted;
      int          hold, sel, a, b;
      apply_reset();
      q.delete();
      model_ovf = 1'b0;
      armed     = 1'b1;
      run_len   = 0;
      zero_len  = 0;
      run_key   = 0;
      for (int it = 0; it < 120; it++) begin
         sel = $urandom_range(0, 99);
         a   = $urandom_range(0, 15);
         b   = $urandom_range(0, 15);
         if (sel < 40)      pat = 16'h0;
         else if (sel < 85) pat = 16'h1 << a;
         else               pat = (16'h1 << a) | (16'h1 << b);
         hold = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) begin
            with_pop = ($urandom_range(0, 3) == 0);
            do_tick(pat, with_pop);
            accepted = 1'b0;
            k = 0;
            for (int i = 0; i < 16; i++) if (pat[i]) k = i;
            if (armed) begin
               if ($countones(pat) == 1) begin
                  if (run_len > 0 && k == run_key) run_len++;
                  else if (run_len == 0) begin run_key = k; run_len = 1; end
                  else run_len = 0;
               end else begin
                  run_len = 0;
               end
               if (run_len == DB) begin
                  accepted = 1'b1;
                  armed    = 1'b0;
                  zero_len = 0;
                  run_len  = 0;
               end
            end else begin
               if (pat == 16'h0) begin
                  zero_len++;
                  if (zero_len == DB) begin armed = 1'b1; run_len = 0; end
               end else begin
                  zero_len = 0;
               end
            end
            popped = with_pop && (q.size() > 0);
            if (popped) void'(q.pop_front());
            if (accepted) begin
               if (q.size() < DEPTH) q.push_back(4'(run_key));
               else model_ovf = 1'b1;
            end
            tests++; if (key_count !== 4'(q.size())) begin fails++; $display("[TB] FAIL rand_count: got %0d expected %0d", key_count, q.size()); end
            tests++; if (key_valid !== (q.size() > 0)) begin fails++; $display("[TB] FAIL rand_valid: got %0b expected %0b", key_valid, q.size() > 0); end
            tests++; if (overflow !== model_ovf) begin fails++; $display("[TB] FAIL rand_overflow: got %0b expected %0b", overflow, model_ovf); end
            if (q.size() > 0) begin
               tests++; if (key_code !== q[0]) begin fails++; $display("[TB] FAIL rand_code: got %0d expected %0d", key_code, q[0]); end
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            clr_overflow = 1'b1;
            @(negedge clk);
            clr_overflow = 1'b0;
            model_ovf = 1'b0;
            tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL rand_clear: got %0b expected 0", overflow); end
         end
      end
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      rst          = 1'b0;
      sample_tick  = 1'b0;
      pb           = '0;
      rd_en        = 1'b0;
      clr_overflow = 1'b0;
      test_reset();
      test_single_press();
      test_bounce();
      test_chord();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Upstream input stage of the calculator: debounces the 16-button pad, encodes one accepted press into a 4-bit extended-BCD key code, and queues codes in a small FIFO.
- The calculator control FSM pops one code per cycle when it is ready, so no keystroke is lost or double-counted.
- Key codes: 0-9 digits, A div/mod, B times, C plus/minus/sign, D clear, E ans, F equals. The code equals the pb bit index.

Parameters:
- DB_TICKS, 3, consecutive sample_tick samples a pad state must hold to be accepted (press and release); range 1-15.
- DEPTH, 8, FIFO entries; power of two, 2-16.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- sample_tick  in  1  one-cycle enable at the debounce sample rate (from the clock divider).
- pb  in  16  raw pushbuttons, active-high, asynchronous to clk.
- rd_en  in  1  pop request from the control FSM.
- key_code  out  4  FIFO head code; valid only when key_valid=1.
- key_valid  out  1  FIFO not empty.
- key_count  out  PTR_W+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky; set when a push is dropped because the FIFO is full.
- clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, any time, including mid-debounce or mid-pop):
  - FSM goes to IDLE; pointers, counters and key_count go to 0.
  - key_valid=0, key_code=0, overflow=0, 2-flop synchronizer cleared.
  - FIFO contents are discarded.
- Synchronization: pb passes through a 2-flop synchronizer every clk; the FSM samples the synchronized value only on cycles with sample_tick=1.
- one_hot = exactly one synchronized bit set; idx = that bit's index.
- FSM states:
  - IDLE:
    - on tick with one_hot: cand<=idx, cnt<=1, go to PRESS_DB.
    - zero keys or multiple keys: stay in IDLE.
  - PRESS_DB, on each tick:
    - same single key still pressed: cnt++. When cnt reaches DB_TICKS, issue push(cand) in that same cycle and go to HELD.
    - any other pattern (release, different key, multiple keys): return to IDLE, no push.
    - With DB_TICKS=1, the push happens on the first qualifying tick directly from IDLE (the IDLE->PRESS_DB->HELD path collapses).
  - HELD:
    - on tick with all keys released: cnt<=1, go to REL_DB.
    - any nonzero pattern, including a second key added: stay in HELD, no push. A chord never generates a second code.
  - REL_DB, on each tick:
    - all released: cnt++; at DB_TICKS go to IDLE.
    - any key seen: back to HELD.
- Exactly one push per accepted press. Holding a key never auto-repeats.
- FIFO (first-word-fall-through):
  - key_code is driven from the memory at the read pointer; key_valid=(key_count!=0).
  - A pop occurs when rd_en=1 and key_valid=1. rd_en while empty is ignored, with no state change.
  - Push when not full: write at the write pointer, pointer increments.
  - Push when full and no pop in the same cycle: entry dropped, overflow<=1.
  - Push and pop in the same cycle: both succeed, key_count unchanged. This includes the full case: the slot freed by the pop accepts the push, and there is no overflow.
  - Pointers wrap modulo DEPTH. key_count is PTR_W+1 bits to distinguish full from empty.
- overflow: if clr_overflow and a new overflow event occur in the same cycle, the set wins.
- Latency:
  - Accepting tick to key_valid=1 (FIFO previously empty): 1 clk.
  - Pop to next head on key_code: same edge, combinationally visible in the following cycle.
  - pb edge to first sample: 2 clk of synchronizer plus wait to the next tick.
- Glitches shorter than DB_TICKS ticks produce no push.

Test Plan:
- pb[7] held for 5 ticks then released for 5 ticks (DB_TICKS=3): exactly one push; key_valid=1 and key_code=7 one clk after the 3rd tick; no further pushes.
- pb[3] bounce pattern 1,0,1,1,1 across ticks: single push of code 3 only after three consecutive high samples; a 2-tick glitch on pb[5] produces no push.
- pb[2] held, then pb[9] added while held, then both released: only code 2 queued; pb[1]|pb[4] pressed simultaneously from IDLE: nothing queued.
- 9 distinct presses with rd_en=0 (DEPTH=8): key_count=8, overflow=1, pops return the first 8 codes in order; clr_overflow then clears the flag.
- FIFO full with rd_en=1 held in the cycle an accepted press pushes: key_count stays 8, overflow stays 0, the new code appears last.
- rst asserted during PRESS_DB with 3 entries queued: key_valid=0 and key_count=0 immediately (asynchronously); after release, the next clean press yields a single entry.
